cdc_fifo_src_arbiter: RTL and testbench

Round-robin, burst-locking arbiter that shares the source (write) side of one gray-coded CDC FIFO between NumReq requesters in the source clock domain. Each beat forwarded to the FIFO carries the index of the requester that sent it, so the destination side can demultiplex. Bursts are held together until a last beat or a MaxBurst fairness cap, whichever comes first. The block sits directly in front of the FIFO's src_data/src_valid/src_ready interface and is fully synchronous to the source clock.

---
 rtl/cdc_fifo_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/cdc_fifo_src_arbiter.sv | 126 ++++++++++++
 tb/tb_cdc_fifo_src_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_arb_pkg.sv
// Shared types and helpers for the CDC FIFO source-side arbiter.
package cdc_fifo_arb_pkg;

  // IDLE: arbitrating; STALL: choice frozen while FIFO is not ready; BURST: grant locked.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    BURST = 2'd2
  } arb_state_e;

  // Round-robin successor of ptr, wrapping at n (works for non-power-of-two n).
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of valid_i scanning upward from ptr_i with wrap-around.
module rr_pick #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   valid_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_o
);

  int unsigned j;

  // Scan offsets 0..NumReq-1 from ptr_i; the first valid one wins, else idx_o = ptr_i.
  always_comb begin
    idx_o = ptr_i;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      j = (32'(ptr_i) + k) % NumReq;
      if (!any_o && valid_i[IdxWidth'(j)]) begin
        any_o = 1'b1;
        idx_o = IdxWidth'(j);
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_src_arbiter.sv
// Round-robin, burst-locking arbiter sharing one CDC FIFO source port among NumReq
// requesters. Every forwarded beat is tagged with its requester index.
module cdc_fifo_src_arbiter
  import cdc_fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter type         T        = logic,
  parameter int unsigned MaxBurst = 16,
  localparam int unsigned IdxWidth = $clog2(NumReq),
  localparam int unsigned CntWidth = $clog2(MaxBurst + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumReq-1:0]     req_valid_i,
  input  T     [NumReq-1:0]     req_data_i,
  input  logic [NumReq-1:0]     req_last_i,
  output logic [NumReq-1:0]     req_ready_o,
  output T                      fifo_data_o,
  output logic [IdxWidth-1:0]   fifo_idx_o,
  output logic                  fifo_valid_o,
  input  logic                  fifo_ready_i,
  output logic                  busy_o
);

  arb_state_e            state_q, state_d;
  logic [IdxWidth-1:0]   ptr_q, ptr_d;
  logic [IdxWidth-1:0]   sel_q, sel_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  logic [IdxWidth-1:0]   pick_idx;
  logic                  pick_any;
  logic [IdxWidth-1:0]   owner;
  logic                  hs;
  logic                  is_end;

  rr_pick #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_rr_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Owner selection and the combinational output mux (no added latency).
  always_comb begin
    owner        = (state_q == IDLE) ? pick_idx : sel_q;
    fifo_valid_o = req_valid_i[owner];
    fifo_data_o  = req_data_i[owner];
    fifo_idx_o   = owner;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = fifo_ready_i & (owner == IdxWidth'(i));
    end
    hs     = fifo_valid_o & fifo_ready_i;
    // cnt_q is zero outside BURST, so MaxBurst == 1 makes every beat an end.
    is_end = req_last_i[owner] | ((32'(cnt_q) + 32'd1) == MaxBurst);
    busy_o = (state_q != IDLE);
  end

  // Next-state logic: lock on stall or unfinished burst, advance pointer on release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, STALL: begin
        if (hs) begin
          if (is_end) begin
            state_d = IDLE;
            ptr_d   = IdxWidth'(rr_next(32'(owner), NumReq));
            cnt_d   = '0;
          end else begin
            state_d = BURST;
            sel_d   = owner;
            cnt_d   = CntWidth'(1);
          end
        end else if (state_q == IDLE && fifo_valid_o) begin
          // Freeze the choice so the FIFO sees stable valid/data.
          state_d = STALL;
          sel_d   = owner;
        end
      end
      BURST: begin
        // Owner dropping valid keeps the lock; there is no timeout.
        if (hs) begin
          if (is_end) begin
            state_d = IDLE;
            ptr_d   = IdxWidth'(rr_next(32'(sel_q), NumReq));
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, selection and burst-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // A stalled owner must hold valid and data until the FIFO accepts the beat.
  a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == STALL) |-> (fifo_valid_o && $stable(fifo_data_o)));

  a_cnt_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(cnt_q) < MaxBurst);

  a_sel_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(sel_q) < NumReq);

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Directed bench for cdc_fifo_src_arbiter with a scoreboard of expected (idx, data) beats.
module tb_cdc_fifo_src_arbiter;

  localparam int unsigned NumReq   = 4;
  localparam int unsigned MaxBurst = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic                        clk_i = 1'b0;
  logic                        rst_ni = 1'b0;
  logic [NumReq-1:0]           req_valid_i = '0;
  logic [NumReq-1:0][7:0]      req_data_i = '0;
  logic [NumReq-1:0]           req_last_i = '0;
  logic [NumReq-1:0]           req_ready_o;
  logic [7:0]                  fifo_data_o;
  logic [1:0]                  fifo_idx_o;
  logic                        fifo_valid_o;
  logic                        fifo_ready_i = 1'b1;
  logic                        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  beat_t      src_q [NumReq][$];
  logic [1:0] exp_idx_q [$];
  logic [7:0] exp_data_q [$];
  bit         hs_fire;
  logic [1:0] hs_idx;

  cdc_fifo_src_arbiter #(
    .NumReq   (NumReq),
    .T        (logic [7:0]),
    .MaxBurst (MaxBurst)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_last_i   (req_last_i),
    .req_ready_o  (req_ready_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_idx_o   (fifo_idx_o),
    .fifo_valid_o (fifo_valid_o),
    .fifo_ready_i (fifo_ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present the head of every requester queue on the inputs.
  task automatic drive();
    for (int i = 0; i < NumReq; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid_i[i] = 1'b1;
        req_data_i[i]  = src_q[i][0].data;
        req_last_i[i]  = src_q[i][0].last;
      end else begin
        req_valid_i[i] = 1'b0;
        req_data_i[i]  = '0;
        req_last_i[i]  = 1'b0;
      end
    end
  endtask

  // Advance one clock; retire the beat accepted in the cycle that just ended.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (hs_fire) void'(src_q[hs_idx].pop_front());
    drive();
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[r].push_back(b);
  endtask

  task automatic expect_beat(input logic [1:0] idx, input logic [7:0] d);
    exp_idx_q.push_back(idx);
    exp_data_q.push_back(d);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int left;
    left = budget;
    while (exp_idx_q.size() > 0 && left > 0) begin
      step();
      left--;
    end
    chk({name, "_drained"}, 32'(exp_idx_q.size()), 32'd0);
    exp_idx_q.delete();
    exp_data_q.delete();
  endtask

  task automatic monitor();
    logic [1:0] e_i;
    logic [7:0] e_d;
    forever begin
      @(negedge clk_i);
      hs_fire = rst_ni && fifo_valid_o && fifo_ready_i;
      hs_idx  = fifo_idx_o;
      if (hs_fire) begin
        if (exp_idx_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got idx %0d data %0h, expected none", fifo_idx_o,
                   fifo_data_o);
        end else begin
          e_i = exp_idx_q.pop_front();
          e_d = exp_data_q.pop_front();
          chk("beat_idx", 32'(fifo_idx_o), 32'(e_i));
          chk("beat_data", 32'(fifo_data_o), 32'(e_d));
          chk("beat_ready_onehot", 32'(req_ready_o), 32'd1 << e_i);
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        // Reset state.
        drive();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_valid", 32'(fifo_valid_o), 32'd0);
        chk("rst_idx_is_ptr", 32'(fifo_idx_o), 32'd0);
        rst_ni = 1'b1;

        // All four valid, last on every beat: 0,1,2,3,0 back to back.
        push_src(0, 8'h00, 1'b1); push_src(0, 8'h01, 1'b1);
        push_src(1, 8'h10, 1'b1); push_src(2, 8'h20, 1'b1); push_src(3, 8'h30, 1'b1);
        expect_beat(2'd0, 8'h00); expect_beat(2'd1, 8'h10); expect_beat(2'd2, 8'h20);
        expect_beat(2'd3, 8'h30); expect_beat(2'd0, 8'h01);
        drive();
        repeat (5) step();
        chk("rr_no_bubbles", 32'(exp_idx_q.size()), 32'd0);
        wait_drain("rr", 4);
        chk("rr_ptr", 32'(dut.ptr_q), 32'd1);

        // Single beat from req 2 only.
        push_src(2, 8'h21, 1'b1);
        expect_beat(2'd2, 8'h21);
        drive();
        #1;
        chk("single_idx", 32'(fifo_idx_o), 32'd2);
        chk("single_ready", 32'(req_ready_o), 32'b0100);
        step();
        chk("single_ptr", 32'(dut.ptr_q), 32'd3);
        chk("single_idle", 32'(busy_o), 32'd0);
        wait_drain("single", 2);

        // Req 1 burst of 3; req 0 and req 3 join mid-burst; req 3 wins after it.
        push_src(1, 8'h11, 1'b0); push_src(1, 8'h12, 1'b0); push_src(1, 8'h13, 1'b1);
        expect_beat(2'd1, 8'h11); expect_beat(2'd1, 8'h12); expect_beat(2'd1, 8'h13);
        expect_beat(2'd3, 8'h31); expect_beat(2'd0, 8'h02);
        drive();
        step();
        push_src(0, 8'h02, 1'b1); push_src(3, 8'h31, 1'b1);
        drive();
        #1;
        chk("burst_locked_busy", 32'(busy_o), 32'd1);
        chk("burst_locked_idx", 32'(fifo_idx_o), 32'd1);
        wait_drain("burst", 10);

        // MaxBurst=4 forced release: 0,0,0,0,1,0,0,0,0,1,0,0.
        for (int k = 0; k < 10; k++) push_src(0, 8'(k), (k == 9));
        for (int k = 0; k < 4; k++) expect_beat(2'd0, 8'(k));
        expect_beat(2'd1, 8'h14);
        for (int k = 4; k < 8; k++) expect_beat(2'd0, 8'(k));
        expect_beat(2'd1, 8'h15);
        expect_beat(2'd0, 8'h08); expect_beat(2'd0, 8'h09);
        drive();
        step();
        push_src(1, 8'h14, 1'b1); push_src(1, 8'h15, 1'b1);
        drive();
        wait_drain("maxburst", 20);
        chk("maxburst_cnt", 32'(dut.cnt_q), 32'd0);

        // Stall: req 2 owns in IDLE with FIFO not ready; req 0 also valid.
        fifo_ready_i = 1'b0;
        push_src(2, 8'h2A, 1'b1); push_src(0, 8'h0A, 1'b1);
        expect_beat(2'd2, 8'h2A); expect_beat(2'd0, 8'h0A);
        drive();
        #1;
        chk("stall_idx0", 32'(fifo_idx_o), 32'd2);
        for (int c = 0; c < 3; c++) begin
          step();
          chk("stall_idx", 32'(fifo_idx_o), 32'd2);
          chk("stall_data", 32'(fifo_data_o), 32'h2A);
          chk("stall_busy", 32'(busy_o), 32'd1);
          chk("stall_ready", 32'(req_ready_o), 32'd0);
        end
        fifo_ready_i = 1'b1;
        wait_drain("stall", 6);

        // Asynchronous reset mid-burst with cnt_q == 3.
        for (int k = 0; k < 6; k++) push_src(3, 8'h40 + 8'(k), (k == 5));
        expect_beat(2'd3, 8'h40); expect_beat(2'd3, 8'h41); expect_beat(2'd3, 8'h42);
        drive();
        repeat (3) step();
        chk("pre_rst_cnt", 32'(dut.cnt_q), 32'd3);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        chk("async_rst_ptr", 32'(dut.ptr_q), 32'd0);
        chk("async_rst_cnt", 32'(dut.cnt_q), 32'd0);
        chk("rst_partial_delivered", 32'(exp_idx_q.size()), 32'd0);
        src_q[3].delete();
        push_src(2, 8'h2B, 1'b1); push_src(1, 8'h1B, 1'b1);
        expect_beat(2'd1, 8'h1B); expect_beat(2'd2, 8'h2B);
        drive();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        wait_drain("post_rst", 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    join_any
  end

endmodule
